// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the write-back data cache.
// Address field widths, FSM states and the store byte-merge.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_t;

  localparam int OFF_W = 2;

  function automatic int woff_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int aw, input int lines,
                               input int words);
    return aw - $clog2(lines) - $clog2(words) - OFF_W;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// dcache_data_array: line data store, one port.
// Byte-enabled synchronous write, combinational read.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int AW             = $clog2(NUM_LINES * WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [NUM_LINES*WORDS_PER_LINE];

  // write merges only the enabled bytes into the stored word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= byte_merge(mem[addr], wdata, be);
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back, write-allocate data cache.
// Optional hit/miss counters enabled by DCACHE_STATS_EN.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int WOFF = woff_w(WORDS_PER_LINE);
  localparam int IDX  = idx_w(NUM_LINES);
  localparam int TAG  = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
  localparam logic [WOFF-1:0] LAST_K = WOFF'(WORDS_PER_LINE - 1);

  state_t state, state_nx;

  logic [ADDR_W-3:0] req_addr;
  logic              req_we;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic [WOFF-1:0]   k;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG-1:0]       tags [NUM_LINES];

  logic [TAG-1:0]  req_tag;
  logic [IDX-1:0]  req_idx;
  logic [WOFF-1:0] req_woff;
  logic            hit;
  logic            last_k;

  logic [WOFF-1:0] arr_word;
  logic            arr_we;
  logic [3:0]      arr_be;
  logic [31:0]     arr_wdata;
  logic [31:0]     arr_rdata;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign req_tag  = req_addr[ADDR_W-3 -: TAG];
  assign req_idx  = req_addr[WOFF +: IDX];
  assign req_woff = req_addr[WOFF-1:0];
  assign hit      = valid[req_idx] && (tags[req_idx] == req_tag);
  assign last_k   = (k == LAST_K);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (cpu_req) state_nx = LOOKUP;
      LOOKUP: begin
        if (hit)                                state_nx = RESP;
        else if (valid[req_idx] && dirty[req_idx]) state_nx = WB;
        else                                    state_nx = FILL;
      end
      WB:     if (mem_ready && last_k) state_nx = FILL;
      FILL:   if (mem_ready && last_k) state_nx = LOOKUP;
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs and data-array port control
  always_comb begin
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    arr_word  = k;
    arr_we    = 1'b0;
    arr_be    = req_be;
    arr_wdata = req_wdata;
    unique case (state)
      LOOKUP: begin
        arr_word = req_woff;
        arr_we   = hit && req_we;
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tags[req_idx], req_idx, k, 2'b00};
        mem_wdata = arr_rdata;
      end
      FILL: begin
        mem_req   = 1'b1;
        mem_addr  = {req_tag, req_idx, k, 2'b00};
        arr_we    = mem_ready;
        arr_be    = 4'hF;
        arr_wdata = mem_rdata;
      end
      RESP:    cpu_ready = 1'b1;
      default: ;
    endcase
  end

  // request capture, word counter, line status and load data
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_be    <= '0;
      req_wdata <= '0;
      k         <= '0;
      valid     <= '0;
      dirty     <= '0;
      cpu_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr  <= cpu_addr[ADDR_W-1:2];
            req_we    <= cpu_we;
            req_be    <= cpu_be;
            req_wdata <= cpu_wdata;
          end
        end
        LOOKUP: begin
          k <= '0;
          if (hit) begin
            if (req_we) dirty[req_idx] <= 1'b1;
            else        cpu_rdata      <= arr_rdata;
          end
        end
        WB: begin
          if (mem_ready) begin
            k <= k + 1'b1;
            if (last_k) dirty[req_idx] <= 1'b0;
          end
        end
        FILL: begin
          if (mem_ready) begin
            k <= k + 1'b1;
            if (last_k) valid[req_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // tag store, written when the last fill word lands
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ready && last_k) begin
      tags[req_idx] <= req_tag;
    end
  end

  dcache_data_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data (
    .clk   (clk),
    .addr  ({req_idx, arr_word}),
    .we    (arr_we),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

`ifdef DCACHE_STATS_EN
  logic        first;
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // first-lookup tracking so the post-fill retry is not a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      first  <= 1'b0;
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (state == IDLE && cpu_req) first <= 1'b1;
      if (state == LOOKUP) begin
        if (!hit) begin
          miss_q <= miss_q + 32'd1;
          first  <= 1'b0;
        end else if (first) begin
          hit_q <= hit_q + 32'd1;
        end
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: self-checking bench for dcache_wb.
// Vector table for hits plus sequences for evictions, stalls, reset.
module tb_dcache_wb;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dcache_wb #(
    .NUM_LINES      (64),
    .WORDS_PER_LINE (4),
    .ADDR_W         (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mop_t;

  typedef struct {
    logic        we;
    logic [31:0] rd;
  } cexp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int lat = 0;
  bit chk_stable = 1'b0;
  int m_hit = 0;
  int m_miss = 0;

  logic [31:0] mem [0:1023];
  mop_t  mq[$];
  cexp_t cq[$];
  vec_t  tv[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic push_line(input logic we, input logic [31:0] base,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    mq.push_back('{we, base,         d0});
    mq.push_back('{we, base + 32'h4, d1});
    mq.push_back('{we, base + 32'h8, d2});
    mq.push_back('{we, base + 32'hC, d3});
  endtask

  task automatic chk_counters();
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 32'(m_hit));
    chk("miss_count", miss_count, 32'(m_miss));
`else
    chk("hit_count", hit_count, 32'd0);
    chk("miss_count", miss_count, 32'd0);
`endif
  endtask

  // memory model: answers after lat wait cycles, checks every access
  initial begin
    int cnt;
    logic [31:0] ha;
    mop_t e;
    cnt = 0;
    ha = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (rst || !mem_req) begin
        cnt = 0;
      end else begin
        if (cnt == 0) ha = mem_addr;
        else if (chk_stable) chk("mem_addr_stable", mem_addr, ha);
        if (cnt >= lat) begin
          mem_ready = 1'b1;
          cnt = 0;
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[11:2]];
          if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: got we=%0d addr %h, required no access",
                     mem_we, mem_addr);
          end else begin
            e = mq.pop_front();
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdata", mem_wdata, e.data);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_lat,
                        input bit miss);
    int n;
    cexp_t e;
    cq.push_back('{we, exp_rd});
    if (miss) m_miss++;
    else      m_hit++;
    cpu_addr  = a;
    cpu_we    = we;
    cpu_be    = be;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cpu_ready && n < 400);
    cpu_req = 1'b0;
    if (!cpu_ready) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout: got no cpu_ready at addr %h, required one", a);
      cq.delete();
    end else begin
      e = cq.pop_front();
      if (!e.we) chk("cpu_rdata", cpu_rdata, e.rd);
      if (exp_lat > 0) chk("hit_latency", 32'(n), 32'(exp_lat));
      chk("mem_pending", 32'(mq.size()), 32'd0);
      chk_counters();
    end
    @(posedge clk);
    #1;
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | (i * 4);
    mem[16] = 32'h11;
    mem[17] = 32'h22;
    mem[18] = 32'h33;
    mem[19] = 32'h44;

    tv[0] = '{1'b0, 32'h48, 4'h0,    32'h0,        32'h33};
    tv[1] = '{1'b1, 32'h44, 4'b0101, 32'hAABBCCDD, 32'h0};
    tv[2] = '{1'b0, 32'h44, 4'h0,    32'h0,        32'h00BB00DD};
    tv[3] = '{1'b0, 32'h4C, 4'h0,    32'h0,        32'h44};
    tv[4] = '{1'b1, 32'h48, 4'hF,    32'hDEADBEEF, 32'h0};
    tv[5] = '{1'b0, 32'h48, 4'h0,    32'h0,        32'hDEADBEEF};
    tv[6] = '{1'b0, 32'h40, 4'h0,    32'h0,        32'h11};

    rst = 1'b1;
    cpu_addr = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_be = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // cold miss, clean fill
    push_line(1'b0, 32'h40, 0, 0, 0, 0);
    cpu_op(1'b0, 32'h40, 4'h0, 32'h0, 32'h11, 0, 1'b1);

    // hits, no memory traffic
    for (int i = 0; i < 7; i++) begin
      cpu_op(tv[i].we, tv[i].addr, tv[i].be, tv[i].wd, tv[i].rd, 2, 1'b0);
    end

    // dirty eviction then fill of the conflicting line
    push_line(1'b1, 32'h40, 32'h11, 32'h00BB00DD, 32'hDEADBEEF, 32'h44);
    push_line(1'b0, 32'h440, 0, 0, 0, 0);
    cpu_op(1'b0, 32'h440, 4'h0, 32'h0, 32'hA000_0440, 0, 1'b1);

    // slow memory; store with no byte enables still dirties the line
    lat = 5;
    chk_stable = 1'b1;
    push_line(1'b0, 32'h80, 0, 0, 0, 0);
    cpu_op(1'b0, 32'h80, 4'h0, 32'h0, 32'hA000_0080, 0, 1'b1);
    cpu_op(1'b1, 32'h84, 4'h0, 32'hFFFF_FFFF, 32'h0, 2, 1'b0);
    push_line(1'b1, 32'h80, 32'hA000_0080, 32'hA000_0084,
              32'hA000_0088, 32'hA000_008C);
    push_line(1'b0, 32'h880, 0, 0, 0, 0);
    cpu_op(1'b0, 32'h880, 4'h0, 32'h0, 32'hA000_0880, 0, 1'b1);
    chk_stable = 1'b0;

    // reset during the second fill word
    lat = 2;
    push_line(1'b0, 32'hC0, 0, 0, 0, 0);
    cpu_addr = 32'hC0;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(mem_req && mem_addr == 32'hC4) && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL rst_wait: got no fill of 000000c4, required one");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_fill_mem_req", 32'(mem_req), 32'd0);
    chk("rst_fill_cpu_ready", 32'(cpu_ready), 32'd0);
    cpu_req = 1'b0;
    rst = 1'b0;
    mq.delete();
    m_hit = 0;
    m_miss = 0;
    chk_counters();
    @(posedge clk);
    #1;

    // every line invalid after reset
    lat = 0;
    push_line(1'b0, 32'h40, 0, 0, 0, 0);
    cpu_op(1'b0, 32'h40, 4'h0, 32'h0, 32'h11, 0, 1'b1);
    push_line(1'b0, 32'h880, 0, 0, 0, 0);
    cpu_op(1'b0, 32'h884, 4'h0, 32'h0, 32'hA000_0884, 0, 1'b1);
    cpu_op(1'b0, 32'h44, 4'h0, 32'h0, 32'h00BB00DD, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache between the RISC-V core load/store unit and data_memory.
- Adds CPU writes with byte enables, per-line dirty bits, dirty-line eviction and multi-word line fill, none of which the earlier read-only cache had.
- Defaults (64 lines x 4 words, 22-bit tag) give a 1 kB data store.

Parameters:
NUM_LINES, 64, number of cache lines; power of two, >= 2
WORDS_PER_LINE, 4, 32-bit words per line; power of two, >= 2
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_req  in  1  request; held with addr/we/be/wdata stable until cpu_ready
cpu_we  in  1  1 = store, 0 = load
cpu_be  in  4  store byte enables
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid while cpu_ready = 1
cpu_ready  out  1  one-cycle completion pulse
mem_addr  out  ADDR_W  word-aligned memory address
mem_req  out  1  memory request; held until mem_ready
mem_we  out  1  1 = write word to memory
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid with mem_ready
mem_ready  in  1  one-cycle memory completion
hit_count  out  32  hits (stats feature)
miss_count  out  32  misses (stats feature)

Behaviour:
- Address split:
  - OFF = 2 bits
  - WOFF = log2(WORDS_PER_LINE)
  - IDX = log2(NUM_LINES)
  - TAG = ADDR_W - IDX - WOFF - 2
- Storage:
  - valid and dirty are flop arrays cleared by rst.
  - tag and data arrays are not reset.
- Reset: all states go to IDLE. cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata and the counters are 0.
- IDLE: when cpu_req = 1, capture addr/we/be/wdata and go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx] == captured tag.
  - Hit load: register data word into cpu_rdata; go to RESP.
  - Hit store: merge bytes where be = 1; set dirty[idx]; go to RESP.
  - Miss with valid && dirty: go to WB, k = 0.
  - Miss otherwise: go to FILL, k = 0.
- WB:
  - Drive mem_req = 1, mem_we = 1, mem_addr = {old tag, idx, k, 2'b00}, mem_wdata = data[idx][k].
  - On mem_ready: k++. After the last word, clear dirty and go to FILL with k = 0.
  - mem_req may stay high across words; the address changes in the cycle after mem_ready.
- FILL:
  - Drive mem_req = 1, mem_we = 0, mem_addr = {new tag, idx, k, 2'b00}.
  - On mem_ready: data[idx][k] = mem_rdata; k++.
  - After the last word: write tag, set valid, go to LOOKUP. The retried lookup is a guaranteed hit; a store then sets dirty.
  - Critical-word forwarding is not supported.
- RESP: cpu_ready = 1 for exactly one cycle, then IDLE. cpu_req sampled during RESP is ignored.
- mem_req deasserts in the cycle after the last mem_ready.
- Latency:
  - Hit: req at cycle 0, ready at cycle 2.
  - Clean miss: 2 + W * (mem latency + 1) + 2.
  - Dirty miss: adds W memory writes.
- cpu_be = 0 on a store: the store completes and the line is still marked dirty.
- mem_ready outside WB/FILL is ignored.
- rst mid-WB/FILL: the operation is abandoned and mem_req = 0 in the next cycle. Dirty contents are lost; this is accepted.
- Counters wrap at 2^32.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - hit_count increments once per LOOKUP that is a hit on first lookup.
  - miss_count increments once per miss. The post-fill lookup is not counted as a hit.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- dcache_pkg holds:
  - the state enum (IDLE, LOOKUP, WB, FILL, RESP)
  - localparam helpers for the OFF/WOFF/IDX/TAG widths
  - a byte-merge function (old word, new word, be) -> word
- One sub-module, dcache_data_array: NUM_LINES x WORDS_PER_LINE x 32, one port, byte-enabled write, combinational read.

Test Plan:
- Cold load of 0x0000_0040, memory returns 0x11,0x22,0x33,0x44 for words 0x40..0x4C -> 4 mem reads at 0x40,0x44,0x48,0x4C; cpu_rdata = 0x11; miss_count = 1.
- Load 0x48 immediately after -> no mem_req; cpu_ready at cycle 2 with 0x33; hit_count = 1.
- Store 0xAABBCCDD be = 4'b0101 to 0x44 (old 0x00000022), then load 0x44 -> 0x00BB00DD; no memory traffic.
- Load 0x440, same index, different tag, line dirty -> 4 mem writes to 0x40..0x4C, including 0x00BB00DD at 0x44, then 4 reads at 0x440..0x44C; cpu_ready once.
- Assert rst during the 2nd FILL word -> mem_req = 0 and cpu_ready = 0 next cycle; all lines invalid; reload of 0x40 misses.
- mem_ready delayed 5 cycles per word -> mem_addr and mem_req stay stable until mem_ready; no duplicate word writes.
